// File: rtl/shift_pkg.sv
// Shared definitions for the iterative shifter: operation and state
// encodings, datapath width, and the shift-count load rule.
package shift_pkg;

   localparam int unsigned SH_WIDTH = 32;
   localparam int unsigned SH_MAX   = 32;

   typedef enum logic [1:0] {
      SH_SLL = 2'b00,
      SH_SRL = 2'b01,
      SH_SRA = 2'b10,
      SH_ROR = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_t;

   // Number of one-bit steps for a request. Logical/arithmetic shifts
   // saturate at the word width (anything past 32 gives the same result);
   // rotates are periodic in the width, so only the low five bits matter.
   function automatic logic [5:0] load_count(input op_t op, input logic [5:0] shamt);
      logic [5:0] n;
      n = '0;
      if (op == SH_ROR)
         n = {1'b0, shamt[4:0]};
      else if (shamt > 6'(SH_MAX))
         n = 6'(SH_MAX);
      else
         n = shamt;
      return n;
   endfunction

endpackage

// File: rtl/shift_step.sv
// One-bit shift/rotate step, purely combinational.
// Ports:
//   value    in  WIDTH  current register contents
//   op       in  2      operation (SLL/SRL/SRA/ROR)
//   next_val out WIDTH  value after a single-position step
module shift_step
   import shift_pkg::*;
#(
   parameter int unsigned WIDTH = SH_WIDTH
) (
   input  logic [WIDTH-1:0] value,
   input  op_t              op,
   output logic [WIDTH-1:0] next_val
);

   always_comb begin
      next_val = value;
      case (op)
         SH_SLL:  next_val = {value[WIDTH-2:0], 1'b0};
         SH_SRL:  next_val = {1'b0, value[WIDTH-1:1]};
         SH_SRA:  next_val = {value[WIDTH-1], value[WIDTH-1:1]};
         SH_ROR:  next_val = {value[0], value[WIDTH-1:1]};
         default: next_val = value;
      endcase
   end

endmodule

// File: rtl/shift_unit.sv
// Iterative 32-bit shifter for the multicycle datapath. Shifts one bit per
// clock and pulses done for one cycle when the result is final.
// Ports:
//   clk      in  1      rising-edge clock
//   reset    in  1      asynchronous, active-low reset
//   start    in  1      request pulse, sampled only while idle
//   op       in  2      00 SLL, 01 SRL, 10 SRA, 11 ROR
//   shamt    in  6      shift amount from the shift-amount mux
//   data_in  in  WIDTH  operand captured on an accepted start
//   data_out out WIDTH  shift register contents
//   busy     out 1      high while shifting and during the done cycle
//   done     out 1      one-cycle completion pulse
module shift_unit
   import shift_pkg::*;
#(
   parameter int unsigned WIDTH = SH_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [5:0]       shamt,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             busy,
   output logic             done
);

   state_t           state;
   op_t              op_q;
   logic [5:0]       count;
   logic [WIDTH-1:0] sreg;
   logic [WIDTH-1:0] step_val;
   logic [5:0]       load_n;

   assign load_n = load_count(op_t'(op), shamt);

   shift_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .value    (sreg),
      .op       (op_q),
      .next_val (step_val)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
         op_q  <= SH_SLL;
         count <= '0;
         sreg  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  sreg  <= data_in;
                  op_q  <= op_t'(op);
                  count <= load_n;
                  state <= (load_n == 6'd0) ? ST_DONE : ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               sreg  <= step_val;
               count <= count - 6'd1;
               if (count == 6'd1)
                  state <= ST_DONE;
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Outputs decode the state register directly, so no input reaches them
   // combinationally.
   assign data_out = sreg;
   assign busy     = (state != ST_IDLE);
   assign done     = (state == ST_DONE);

endmodule

// File: tb/tb_shift_unit.sv
// Self-checking bench for shift_unit: directed cases plus randomized
// requests compared against an arithmetic reference model.
module tb_shift_unit;

   logic        clk;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [5:0]  shamt;
   logic [31:0] data_in;
   logic [31:0] data_out;
   logic        busy;
   logic        done;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   shift_unit #(
      .WIDTH (32)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .op       (op),
      .shamt    (shamt),
      .data_in  (data_in),
      .data_out (data_out),
      .busy     (busy),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Step count the operation takes, from the amount rules.
   function automatic int ref_steps(input logic [1:0] o, input logic [5:0] s);
      if (o == 2'b11) return int'(s) % 32;
      return (int'(s) > 32) ? 32 : int'(s);
   endfunction

   // Final result, written as whole-word arithmetic.
   function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [5:0] s,
                                              input logic [31:0] d);
      int unsigned n;
      logic [63:0] dbl;
      n = int'(s) > 32 ? 32 : int'(s);
      case (o)
         2'b00: return (n >= 32) ? 32'h0 : (d << n);
         2'b01: return (n >= 32) ? 32'h0 : (d >> n);
         2'b10: begin
            if (d[31]) return (n >= 32) ? 32'hFFFF_FFFF : ~((~d) >> n);
            return (n >= 32) ? 32'h0 : (d >> n);
         end
         default: begin
            dbl = {d, d} >> (int'(s) % 32);
            return dbl[31:0];
         end
      endcase
   endfunction

   // Issue one request, optionally disturbing inputs while busy, then verify
   // latency, busy, result, and that a start during done is ignored.
   task automatic do_op(input logic [1:0] o, input logic [5:0] s, input logic [31:0] d,
                        input bit noise, input string tag);
      int          n;
      int          cycles;
      logic [31:0] exp;
      bit          busy_ok;
      n   = ref_steps(o, s);
      exp = ref_result(o, s, d);
      @(negedge clk);
      op = o; shamt = s; data_in = d; start = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      cycles  = 1;
      busy_ok = 1'b1;
      while (cycles <= 40 && !done) begin
         if (!busy) busy_ok = 1'b0;
         if (noise) begin
            start   = $urandom_range(0, 1);
            op      = 2'($urandom);
            shamt   = 6'($urandom);
            data_in = $urandom;
         end
         @(negedge clk);
         cycles++;
      end
      check({tag, " busy_during"}, 32'(busy_ok), 32'd1);
      check({tag, " latency"}, 32'(cycles), 32'(n + 1));
      check({tag, " result"}, data_out, exp);
      check({tag, " busy_at_done"}, 32'(busy), 32'd1);
      // start coinciding with done must not be accepted
      start = 1'b1; data_in = ~d; op = 2'b00; shamt = 6'd1;
      @(negedge clk);
      start = 1'b0;
      check({tag, " idle_after"}, {30'b0, busy, done}, 32'd0);
      check({tag, " held"}, data_out, exp);
   endtask

   initial begin
      int unsigned cyc;
      reset = 1'b0; start = 1'b0; op = 2'b00; shamt = '0; data_in = '0;
      #12;
      check("reset_data", data_out, 32'h0);
      check("reset_flags", {30'b0, busy, done}, 32'd0);
      @(negedge clk);
      reset = 1'b1;

      do_op(2'b00, 6'd4,  32'h0000_0001, 1'b0, "sll4");
      check("sll4_value", data_out, 32'h0000_0010);
      do_op(2'b10, 6'd16, 32'h8000_0000, 1'b0, "sra16");
      check("sra16_value", data_out, 32'hFFFF_8000);
      do_op(2'b01, 6'd16, 32'h8000_0000, 1'b0, "srl16");
      check("srl16_value", data_out, 32'h0000_8000);
      do_op(2'b01, 6'd40, 32'h8000_0000, 1'b0, "srl40");
      check("srl40_value", data_out, 32'h0000_0000);
      do_op(2'b10, 6'd63, 32'h8000_0000, 1'b0, "sra63");
      check("sra63_value", data_out, 32'hFFFF_FFFF);
      do_op(2'b11, 6'd36, 32'h0000_00F1, 1'b0, "ror36");
      check("ror36_value", data_out, 32'h1000_000F);
      do_op(2'b00, 6'd0,  32'hDEAD_BEEF, 1'b0, "sll0");
      check("sll0_value", data_out, 32'hDEAD_BEEF);
      do_op(2'b00, 6'd8,  32'hDEAD_BEEF, 1'b1, "sll8_busy_start");
      check("sll8_value", data_out, 32'hADBE_EF00);
      do_op(2'b11, 6'd32, 32'h1234_5678, 1'b0, "ror32");
      check("ror32_value", data_out, 32'h1234_5678);

      // asynchronous reset in the middle of a 20-bit shift
      @(negedge clk);
      op = 2'b00; shamt = 6'd20; data_in = 32'h0000_0001; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      check("mid_busy", 32'(busy), 32'd1);
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      check("async_rst_data", data_out, 32'h0);
      check("async_rst_flags", {30'b0, busy, done}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      do_op(2'b00, 6'd1, 32'h0000_0001, 1'b0, "post_reset");
      check("post_reset_value", data_out, 32'h0000_0002);

      for (int i = 0; i < 150; i++) begin
         do_op(2'($urandom), 6'($urandom), $urandom, 1'($urandom), "rand");
      end

      // idle gap: outputs must not follow inputs without a start
      cyc = 0;
      data_in = 32'hA5A5_A5A5;
      repeat (3) begin
         @(negedge clk);
         if (busy) cyc++;
      end
      check("idle_no_start", 32'(cyc), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
